// File: rtl/spi_master_periph_pkg.sv
// Shared constants for the SPI master peripheral: register bit positions,
// FSM encoding, data width and the SCK half-period helper.
package spi_master_periph_pkg;

    localparam int DATA_W = 8;

    // SCON control register layout
    localparam int SCON_EN_BIT   = 7;
    localparam int SCON_CPOL_BIT = 3;
    localparam int SCON_CPHA_BIT = 2;
    localparam int SCON_DIV_MSB  = 1;
    localparam int SCON_DIV_LSB  = 0;

    // Status byte layout
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_WCOL_BIT = 2;
    localparam int STAT_OVR_BIT  = 3;

    // Number of SCK half-periods in one byte transfer
    localparam int HALF_PERIODS = 2 * DATA_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Last count value of one SCK half-period: H = 2^(div+1) clk cycles.
    function automatic logic [3:0] half_last(input logic [1:0] div);
        logic [4:0] h;
        h = 5'd2 << div;
        return 4'(h - 5'd1);
    endfunction

endpackage

// File: rtl/spi_master_periph_if.sv
// CPU-side register bus of the SPI master peripheral.
interface spi_master_periph_if;
    import spi_master_periph_pkg::*;

    logic              sconEn;
    logic              spiStatRead;
    logic              spiBufRead;
    logic              spiBufWrite;
    logic              spiBufShift;
    logic [DATA_W-1:0] dataIn;
    logic [DATA_W-1:0] dataOut;

    modport master (
        output sconEn, spiStatRead, spiBufRead, spiBufWrite, spiBufShift, dataIn,
        input  dataOut
    );

    modport slave (
        input  sconEn, spiStatRead, spiBufRead, spiBufWrite, spiBufShift, dataIn,
        output dataOut
    );

endinterface

// File: rtl/spi_master_periph_clk_gen.sv
// SCK timing for one transfer: half-period counter that strikes the leading and
// trailing edges and flags the final trailing edge of the byte.
module spi_clk_gen
    import spi_master_periph_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] div,
    output logic       lead,
    output logic       trail,
    output logic       last
);

    logic [3:0] cnt_reg;
    logic [3:0] half_reg;
    logic       phase_reg;
    logic       strike;

    assign strike = run && (cnt_reg == half_last(div));
    assign lead   = strike && !phase_reg;
    assign trail  = strike && phase_reg;
    assign last   = trail && (half_reg == 4'(HALF_PERIODS - 1));

    // Held at zero outside SHIFT so every transfer starts on a fresh half-period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            half_reg  <= '0;
            phase_reg <= 1'b0;
        end else if (!run) begin
            cnt_reg   <= '0;
            half_reg  <= '0;
            phase_reg <= 1'b0;
        end else if (strike) begin
            cnt_reg   <= '0;
            half_reg  <= half_reg + 4'd1;
            phase_reg <= ~phase_reg;
        end else begin
            cnt_reg   <= cnt_reg + 4'd1;
        end
    end

endmodule

// File: rtl/spi_master_periph.sv
// Byte-wide SPI master with SCON/status/buffer registers and sticky error flags.
// Define SPI_MODE_SELECT_EN to enable CPOL/CPHA (SCON[3:2]); otherwise mode 0 only.
module spi_master_periph
    import spi_master_periph_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    spi_master_periph_if.slave   bus,
    output logic                 sck,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 ssN
);

    state_t            state_reg;
    logic              scon_en_reg;
    logic              cpol_reg;
    logic              cpha_reg;
    logic [1:0]        div_reg;
    logic [DATA_W-1:0] tx_buf_reg;
    logic [DATA_W-1:0] rx_buf_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              miso_bit_reg;
    logic              done_reg;
    logic              wcol_reg;
    logic              ovr_reg;
    logic              sck_reg;
    logic              mosi_reg;
    logic              ssn_reg;

    logic              busy;
    logic              lead;
    logic              trail;
    logic              last;
    logic              cpol_in;
    logic              cpha_in;
    logic              abort;
    logic              scon_wr;
    logic [DATA_W-1:0] tx_byte;
    logic [DATA_W-1:0] shift_next;
    logic [DATA_W-1:0] status;

`ifdef SPI_MODE_SELECT_EN
    assign cpol_in = bus.dataIn[SCON_CPOL_BIT];
    assign cpha_in = bus.dataIn[SCON_CPHA_BIT];
`else
    assign cpol_in = 1'b0;
    assign cpha_in = 1'b0;
`endif

    assign busy    = (state_reg == ST_SHIFT);
    assign abort   = busy && bus.sconEn && !bus.dataIn[SCON_EN_BIT];
    // While busy only a disabling write reaches SCON; an enabling one is a collision.
    assign scon_wr = bus.sconEn && (!busy || !bus.dataIn[SCON_EN_BIT]);
    assign tx_byte = bus.spiBufWrite ? bus.dataIn : tx_buf_reg;
    assign shift_next = {shift_reg[DATA_W-2:0], (cpha_reg ? miso : miso_bit_reg)};

    spi_clk_gen u_clk_gen (
        .clk   (clk),
        .reset (reset),
        .run   (busy),
        .div   (div_reg),
        .lead  (lead),
        .trail (trail),
        .last  (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            scon_en_reg  <= 1'b0;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            div_reg      <= '0;
            tx_buf_reg   <= '0;
            rx_buf_reg   <= '0;
            shift_reg    <= '0;
            miso_bit_reg <= 1'b0;
            done_reg     <= 1'b0;
            wcol_reg     <= 1'b0;
            ovr_reg      <= 1'b0;
            sck_reg      <= 1'b0;
            mosi_reg     <= 1'b0;
            ssn_reg      <= 1'b1;
        end else begin
            // Read-clears come first so a same-cycle set below wins.
            if (bus.spiStatRead) begin
                wcol_reg <= 1'b0;
                ovr_reg  <= 1'b0;
            end
            if (bus.spiBufRead) begin
                done_reg <= 1'b0;
            end
            if (scon_wr) begin
                scon_en_reg <= bus.dataIn[SCON_EN_BIT];
                cpol_reg    <= cpol_in;
                cpha_reg    <= cpha_in;
                div_reg     <= bus.dataIn[SCON_DIV_MSB:SCON_DIV_LSB];
            end

            case (state_reg)
                ST_IDLE: begin
                    sck_reg <= bus.sconEn ? cpol_in : cpol_reg;
                    if (bus.spiBufWrite) begin
                        tx_buf_reg <= bus.dataIn;
                    end
                    if (bus.spiBufShift && scon_en_reg) begin
                        state_reg <= ST_SHIFT;
                        ssn_reg   <= 1'b0;
                        shift_reg <= tx_byte;
                        mosi_reg  <= tx_byte[DATA_W-1];
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        ssn_reg   <= 1'b1;
                        sck_reg   <= cpol_in;
                    end else begin
                        if (bus.sconEn || bus.spiBufWrite || bus.spiBufShift) begin
                            wcol_reg <= 1'b1;
                        end
                        if (lead || trail) begin
                            sck_reg <= ~sck_reg;
                        end
                        if (lead) begin
                            if (cpha_reg) mosi_reg <= shift_reg[DATA_W-1];
                            else          miso_bit_reg <= miso;
                        end
                        if (trail) begin
                            shift_reg <= shift_next;
                            if (!cpha_reg) mosi_reg <= shift_reg[DATA_W-2];
                        end
                        if (last) begin
                            state_reg  <= ST_IDLE;
                            ssn_reg    <= 1'b1;
                            rx_buf_reg <= shift_next;
                            done_reg   <= 1'b1;
                            if (done_reg) ovr_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        status                = '0;
        status[STAT_BUSY_BIT] = busy;
        status[STAT_DONE_BIT] = done_reg;
        status[STAT_WCOL_BIT] = wcol_reg;
        status[STAT_OVR_BIT]  = ovr_reg;
    end

    assign bus.dataOut = bus.spiStatRead ? status :
                         bus.spiBufRead  ? rx_buf_reg : '0;

    assign sck  = sck_reg;
    assign mosi = mosi_reg;
    assign ssN  = ssn_reg;

endmodule

// File: tb/tb_spi_master_periph.sv
// Directed self-checking bench for spi_master_periph: loopback and modelled-slave
// transfers, collision/overrun flags, abort and asynchronous reset.
module tb_spi_master_periph;

    logic clk = 1'b0;
    logic reset;
    logic sck, mosi, miso, ssN;

    spi_master_periph_if bus_if ();

    spi_master_periph dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .sck   (sck),
        .mosi  (mosi),
        .miso  (miso),
        .ssN   (ssN)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave model: loopback or a fixed byte shifted out on the slave's launch edge.
    logic       loop_en     = 1'b1;
    logic       slave_mode3 = 1'b0;
    logic [7:0] slave_pat   = 8'h00;
    logic       slave_bit;
    int         slv_cnt     = 0;
    int         slave_idx;
    int         sck_rises   = 0;

    always @(posedge sck) sck_rises++;

    always @(negedge sck or posedge ssN) begin
        if (ssN) slv_cnt <= 0;
        else     slv_cnt <= slv_cnt + 1;
    end

    always_comb begin
        slave_bit = 1'b0;
        slave_idx = slave_mode3 ? slv_cnt - 1 : slv_cnt;
        if (slave_idx >= 0 && slave_idx < 8) slave_bit = slave_pat[3'(7 - slave_idx)];
    end

    assign miso = loop_en ? mosi : slave_bit;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end else begin
            $display("ok   %s = %02h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus_if.sconEn      = 1'b0;
        bus_if.spiStatRead = 1'b0;
        bus_if.spiBufRead  = 1'b0;
        bus_if.spiBufWrite = 1'b0;
        bus_if.spiBufShift = 1'b0;
        bus_if.dataIn      = 8'h00;
    endtask

    task automatic scon_write(input logic [7:0] v);
        bus_if.sconEn = 1'b1;
        bus_if.dataIn = v;
        tick();
        bus_idle();
    endtask

    task automatic buf_write(input logic [7:0] v);
        bus_if.spiBufWrite = 1'b1;
        bus_if.dataIn      = v;
        tick();
        bus_idle();
    endtask

    // Write and shift in the same cycle.
    task automatic start_xfer(input logic [7:0] v);
        bus_if.spiBufWrite = 1'b1;
        bus_if.spiBufShift = 1'b1;
        bus_if.dataIn      = v;
        tick();
        bus_idle();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (ssN === 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        check_val("xfer_timeout", {7'b0, (n >= 2000)}, 8'h00);
    endtask

    // Combinational read with no clock edge, so nothing is cleared.
    task automatic peek(input string tag, input logic stat, input logic bufr, input logic [7:0] exp);
        bus_if.spiStatRead = stat;
        bus_if.spiBufRead  = bufr;
        #1;
        check_val(tag, bus_if.dataOut, exp);
        bus_if.spiStatRead = 1'b0;
        bus_if.spiBufRead  = 1'b0;
    endtask

    // Clocked read: value checked, then the read edge applies its clear.
    task automatic read_reg(input string tag, input logic stat, input logic [7:0] exp);
        bus_if.spiStatRead = stat;
        bus_if.spiBufRead  = !stat;
        #1;
        check_val(tag, bus_if.dataOut, exp);
        tick();
        bus_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int r0;
        logic [7:0] exp_idle;

        bus_idle();
        reset = 1'b1;
        repeat (2) tick();
        check_val("rst_ssN", {7'b0, ssN}, 8'h01);
        check_val("rst_sck", {7'b0, sck}, 8'h00);
        check_val("rst_mosi", {7'b0, mosi}, 8'h00);
        reset = 1'b0;
        tick();
        peek("rst_status", 1'b1, 1'b0, 8'h00);
        peek("rst_rx", 1'b0, 1'b1, 8'h00);
        peek("rst_dout_none", 1'b0, 1'b0, 8'h00);

        // Shift while disabled is ignored, no flag set.
        bus_if.spiBufShift = 1'b1;
        tick();
        bus_idle();
        check_val("dis_shift_ssN", {7'b0, ssN}, 8'h01);
        peek("dis_shift_stat", 1'b1, 1'b0, 8'h00);

        // Mode 0, div 0, loopback of A5.
        loop_en = 1'b1;
        scon_write(8'h80);
        buf_write(8'hA5);
        r0 = sck_rises;
        bus_if.spiBufShift = 1'b1;
        tick();
        bus_idle();
        peek("t1_busy_stat", 1'b1, 1'b0, 8'h01);
        wait_idle(n);
        check_val("t1_busy_cycles", 8'(n), 8'd32);
        check_val("t1_sck_rises", 8'(sck_rises - r0), 8'd8);
        check_val("t1_ssN_end", {7'b0, ssN}, 8'h01);
        peek("t1_prio_stat", 1'b1, 1'b1, 8'h02);
        read_reg("t1_status", 1'b1, 8'h02);
        read_reg("t1_rx", 1'b0, 8'hA5);
        peek("t1_done_clr", 1'b1, 1'b0, 8'h00);

        // Write collision during transfer leaves the data intact.
        buf_write(8'h96);
        bus_if.spiBufShift = 1'b1;
        tick();
        bus_idle();
        repeat (3) tick();
        buf_write(8'h3C);
        bus_if.spiStatRead = 1'b1;
        #1;
        check_val("t2_wcol_set", bus_if.dataOut, 8'h05);
        tick();
        check_val("t2_wcol_clr", bus_if.dataOut, 8'h01);
        bus_idle();
        wait_idle(n);
        read_reg("t2_rx", 1'b0, 8'h96);
        bus_if.spiBufShift = 1'b1;
        tick();
        bus_idle();
        wait_idle(n);
        read_reg("t2_txbuf_kept", 1'b0, 8'h96);

        // Two transfers without reading the buffer -> overrun.
        start_xfer(8'h11);
        wait_idle(n);
        peek("t3_first_rx", 1'b0, 1'b1, 8'h11);
        start_xfer(8'h22);
        wait_idle(n);
        read_reg("t3_overrun", 1'b1, 8'h0A);
        peek("t3_ovr_clr", 1'b1, 1'b0, 8'h02);
        read_reg("t3_rx", 1'b0, 8'h22);
        peek("t3_idle_stat", 1'b1, 1'b0, 8'h00);

        // Abort at cycle 10 of a div=1 transfer.
        scon_write(8'h81);
        start_xfer(8'h77);
        repeat (10) tick();
        bus_if.sconEn = 1'b1;
        bus_if.dataIn = 8'h00;
        tick();
        bus_idle();
        check_val("t4_abort_ssN", {7'b0, ssN}, 8'h01);
        check_val("t4_abort_sck", {7'b0, sck}, 8'h00);
        peek("t4_abort_stat", 1'b1, 1'b0, 8'h00);
        peek("t4_abort_rx", 1'b0, 1'b1, 8'h22);

        // SCON=8C with a slave returning 5A.
        loop_en   = 1'b0;
        slave_pat = 8'h5A;
`ifdef SPI_MODE_SELECT_EN
        slave_mode3 = 1'b1;
        exp_idle    = 8'h01;
`else
        slave_mode3 = 1'b0;
        exp_idle    = 8'h00;
`endif
        scon_write(8'h8C);
        tick();
        check_val("t5_sck_idle_pre", {7'b0, sck}, exp_idle);
        start_xfer(8'hFF);
        wait_idle(n);
        tick();
        check_val("t5_sck_idle_post", {7'b0, sck}, exp_idle);
        read_reg("t5_rx", 1'b0, 8'h5A);

        // Asynchronous reset in the middle of a transfer.
        loop_en = 1'b1;
        scon_write(8'h80);
        start_xfer(8'hF0);
        repeat (5) tick();
        check_val("t6_mid_ssN", {7'b0, ssN}, 8'h00);
        check_val("t6_mid_mosi", {7'b0, mosi}, 8'h01);
        #3;
        reset = 1'b1;
        #1;
        check_val("t6_rst_ssN", {7'b0, ssN}, 8'h01);
        check_val("t6_rst_sck", {7'b0, sck}, 8'h00);
        check_val("t6_rst_mosi", {7'b0, mosi}, 8'h00);
        peek("t6_rst_stat", 1'b1, 1'b0, 8'h00);
        peek("t6_rst_rx", 1'b0, 1'b1, 8'h00);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        peek("t6_post_stat", 1'b1, 1'b0, 8'h00);
        bus_if.spiBufShift = 1'b1;
        tick();
        bus_idle();
        check_val("t6_scon_cleared", {7'b0, ssN}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
